// File: rtl/mat_mult_sched.sv
// Tile scheduler for the NxN signed matrix-multiply datapath: walks C in 2x2 tiles,
// drives A/B RAM read addresses, MAC enable/clear and the serialised C write-back.
module mat_mult_sched #(
  parameter int N   = 8,
  parameter int AW  = 8,
  parameter int CAW = 6,
  parameter int CW  = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic [AW-1:0]  addrA1,
  output logic [AW-1:0]  addrA2,
  output logic [AW-1:0]  addrB1,
  output logic [AW-1:0]  addrB2,
  output logic           mac_en,
  output logic           macc_clear,
  output logic [1:0]     prod_sel,
  output logic           c_we,
  output logic [CAW-1:0] c_addr,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  clock_count
);

  // state   | meaning
  // IDLE    | waiting for start, all outputs quiet
  // FETCH   | issue A/B read addresses for k = 0..N-1 of the current tile
  // DRAIN   | one extra MAC cycle consuming the k = N-1 read data
  // WRITE   | serialise the four tile products into C (s = 0..3)
  // DONE    | run complete, done high, clock_count held

  localparam int LGN = $clog2(N);
  localparam int TW  = LGN - 1;
  localparam logic [TW-1:0]  T_LAST = TW'(N/2 - 1);
  localparam logic [LGN-1:0] K_LAST = LGN'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [TW-1:0]  ti, tj, ti_nxt, tj_nxt;
  logic [LGN-1:0] k, k_nxt;
  logic [1:0]     s, s_nxt;
  logic           launch;

  always_comb begin
    state_nxt = state;
    ti_nxt    = ti;
    tj_nxt    = tj;
    k_nxt     = k;
    s_nxt     = s;
    launch    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = S_FETCH;
          ti_nxt    = '0;
          tj_nxt    = '0;
          k_nxt     = '0;
          s_nxt     = '0;
        end
      end
      S_FETCH: begin
        if (k == K_LAST) state_nxt = S_DRAIN;
        else             k_nxt     = k + LGN'(1);
      end
      S_DRAIN: begin
        state_nxt = S_WRITE;
        s_nxt     = '0;
      end
      S_WRITE: begin
        if (s == 2'd3) begin
          if (ti == T_LAST && tj == T_LAST) begin
            state_nxt = S_DONE;
            ti_nxt    = '0;
            tj_nxt    = '0;
            k_nxt     = '0;
          end else begin
            state_nxt = S_FETCH;
            k_nxt     = '0;
            if (tj == T_LAST) begin
              tj_nxt = '0;
              ti_nxt = ti + TW'(1);
            end else begin
              tj_nxt = tj + TW'(1);
            end
          end
        end else begin
          s_nxt = s + 2'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next-state values so they are registered
  // yet line up with the state they describe.
  logic           on_tile_nxt, is_busy;
  logic [AW-1:0]  i0_a, j0_a, k_a;
  logic [AW-1:0]  a1_nxt, a2_nxt, b1_nxt, b2_nxt;
  logic [CAW-1:0] i0_c, j0_c, c_addr_nxt;
  logic           mac_en_nxt, macc_clear_nxt, c_we_nxt;
  logic [1:0]     prod_sel_nxt;

  always_comb begin
    on_tile_nxt = (state_nxt == S_FETCH) || (state_nxt == S_DRAIN) || (state_nxt == S_WRITE);
    is_busy     = (state == S_FETCH) || (state == S_DRAIN) || (state == S_WRITE);
    i0_a        = AW'({ti_nxt, 1'b0});
    j0_a        = AW'({tj_nxt, 1'b0});
    k_a         = AW'(k_nxt);
    i0_c        = CAW'({ti_nxt, 1'b0});
    j0_c        = CAW'({tj_nxt, 1'b0});
    a1_nxt      = '0;
    a2_nxt      = '0;
    b1_nxt      = '0;
    b2_nxt      = '0;
    if (on_tile_nxt) begin
      a1_nxt = (i0_a << LGN) + k_a;
      a2_nxt = ((i0_a + AW'(1)) << LGN) + k_a;
      b1_nxt = (k_a << LGN) + j0_a;
      b2_nxt = (k_a << LGN) + j0_a + AW'(1);
    end
    mac_en_nxt     = ((state_nxt == S_FETCH) && (k_nxt != '0)) || (state_nxt == S_DRAIN);
    macc_clear_nxt = (state_nxt == S_FETCH) && (k_nxt == LGN'(1));
    c_we_nxt       = (state_nxt == S_WRITE);
    prod_sel_nxt   = c_we_nxt ? s_nxt : 2'd0;
    c_addr_nxt     = '0;
    if (c_we_nxt)
      c_addr_nxt = (i0_c << LGN) + j0_c + (CAW'(s_nxt[1]) << LGN) + CAW'(s_nxt[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ti          <= '0;
      tj          <= '0;
      k           <= '0;
      s           <= '0;
      addrA1      <= '0;
      addrA2      <= '0;
      addrB1      <= '0;
      addrB2      <= '0;
      mac_en      <= 1'b0;
      macc_clear  <= 1'b0;
      prod_sel    <= 2'd0;
      c_we        <= 1'b0;
      c_addr      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      clock_count <= '0;
    end else begin
      state      <= state_nxt;
      ti         <= ti_nxt;
      tj         <= tj_nxt;
      k          <= k_nxt;
      s          <= s_nxt;
      addrA1     <= a1_nxt;
      addrA2     <= a2_nxt;
      addrB1     <= b1_nxt;
      addrB2     <= b2_nxt;
      mac_en     <= mac_en_nxt;
      macc_clear <= macc_clear_nxt;
      prod_sel   <= prod_sel_nxt;
      c_we       <= c_we_nxt;
      c_addr     <= c_addr_nxt;
      busy       <= on_tile_nxt;
      done       <= (state_nxt == S_DONE);
      // Counts completed busy cycles, so it reads N*N/4*(N+5) in the first DONE cycle.
      if (launch)
        clock_count <= '0;
      else if (is_busy && clock_count != '1)
        clock_count <= clock_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_mat_mult_sched.sv
// Bench for mat_mult_sched: models the A/B RAMs, four MACs and the C RAM around
// the scheduler and checks timing, counts and the multiply results.
module tb_mat_mult_sched;
  localparam int N    = 8;
  localparam int AW   = 8;
  localparam int CAW  = 6;
  localparam int CW   = 11;
  localparam int SENT = 999999;
  localparam int MAXC = 400;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [AW-1:0]  addrA1, addrA2, addrB1, addrB2;
  logic           mac_en, macc_clear, c_we, busy, done;
  logic [1:0]     prod_sel;
  logic [CAW-1:0] c_addr;
  logic [CW-1:0]  clock_count;

  always #5 clk = ~clk;

  mat_mult_sched #(.N(N), .AW(AW), .CAW(CAW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .addrA1(addrA1), .addrA2(addrA2), .addrB1(addrB1), .addrB2(addrB2),
    .mac_en(mac_en), .macc_clear(macc_clear), .prod_sel(prod_sel),
    .c_we(c_we), .c_addr(c_addr), .busy(busy), .done(done),
    .clock_count(clock_count)
  );

  int a_mem [0:255];
  int b_mem [0:255];
  int c_mem [0:63];
  int prev_c [0:63];
  int rd_a1, rd_a2, rd_b1, rd_b2;
  int acc11, acc12, acc21, acc22;
  bit c_clr = 1'b0;

  // Surrounding datapath: 1-cycle read RAMs, four MACs, C write port.
  always @(posedge clk) begin
    rd_a1 <= a_mem[addrA1];
    rd_a2 <= a_mem[addrA2];
    rd_b1 <= b_mem[addrB1];
    rd_b2 <= b_mem[addrB2];
    if (mac_en) begin
      acc11 <= macc_clear ? rd_a1 * rd_b1 : acc11 + rd_a1 * rd_b1;
      acc12 <= macc_clear ? rd_a1 * rd_b2 : acc12 + rd_a1 * rd_b2;
      acc21 <= macc_clear ? rd_a2 * rd_b1 : acc21 + rd_a2 * rd_b1;
      acc22 <= macc_clear ? rd_a2 * rd_b2 : acc22 + rd_a2 * rd_b2;
    end
    if (c_clr) begin
      for (int i = 0; i < 64; i++) c_mem[i] <= SENT;
    end else if (c_we) begin
      case (prod_sel)
        2'd0: c_mem[c_addr] <= acc11;
        2'd1: c_mem[c_addr] <= acc12;
        2'd2: c_mem[c_addr] <= acc21;
        default: c_mem[c_addr] <= acc22;
      endcase
    end
  end

  int checks = 0;
  int errors = 0;
  int r_done_cyc, r_count, r_busy, r_we, r_mac, r_clr, r_first_we;
  int s1_a1, s1_a2, s1_b1, s1_b2, s1_count, s1_busy, s1_done;
  int we_log [$];

  function automatic int exp_c(int a);
    int i, j, sum;
    i = a / N;
    j = a % N;
    sum = 0;
    for (int k = 0; k < N; k++) sum += a_mem[i*N+k] * b_mem[k*N+j];
    return sum;
  endfunction

  task automatic clear_c();
    @(negedge clk);
    c_clr = 1'b1;
    @(negedge clk);
    c_clr = 1'b0;
  endtask

  task automatic load_general();
    for (int r = 0; r < N; r++)
      for (int q = 0; q < N; q++) begin
        a_mem[r*N+q] = ((r*7 + q*3) % 23) - 11;
        b_mem[r*N+q] = ((r*5 + q*11) % 29) - 14;
      end
  endtask

  // Launches one run and gathers statistics; p1/p2 are cycles with a stray start pulse.
  task automatic run_mult(input int p1, input int p2);
    int cyc;
    bit fin;
    we_log.delete();
    r_busy = 0; r_we = 0; r_mac = 0; r_clr = 0; r_first_we = 0; r_done_cyc = 0; r_count = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    fin = 1'b0;
    while (!fin && cyc <= MAXC) begin
      if (cyc == 1) begin
        s1_a1 = addrA1; s1_a2 = addrA2; s1_b1 = addrB1; s1_b2 = addrB2;
        s1_count = clock_count; s1_busy = busy; s1_done = done;
      end
      if (busy) r_busy++;
      if (mac_en) r_mac++;
      if (mac_en && macc_clear) r_clr++;
      if (c_we) begin
        if (r_we == 0) r_first_we = cyc;
        r_we++;
        we_log.push_back(int'(c_addr));
      end
      if (done) begin
        fin = 1'b1;
        r_done_cyc = cyc;
        r_count = clock_count;
      end else begin
        start = (cyc == p1 || cyc == p2);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL run_timeout: done not seen, observed %0d cycles, required <= %0d", cyc, MAXC);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({addrA1, addrA2, addrB1, addrB2, mac_en, macc_clear, prod_sel, c_we, c_addr, busy, done, clock_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: addrs %0d %0d %0d %0d mac_en %b clr %b sel %0d we %b caddr %0d busy %b done %b cnt %0d, required all 0",
               addrA1, addrA2, addrB1, addrB2, mac_en, macc_clear, prod_sel, c_we, c_addr, busy, done, clock_count);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_hold: cycle %0d busy %b done %b, required 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_identity();
    int first4 [4] = '{0, 1, 8, 9};
    int last4  [4] = '{54, 55, 62, 63};
    for (int r = 0; r < N; r++)
      for (int q = 0; q < N; q++) begin
        a_mem[r*N+q] = (r == q) ? 1 : 0;
        b_mem[r*N+q] = 8*r + q - 32;
      end
    clear_c();
    run_mult(0, 0);
    checks++;
    if (s1_a1 != 0 || s1_a2 != 8 || s1_b1 != 0 || s1_b2 != 1) begin
      errors++;
      $display("FAIL first_addrs: got %0d %0d %0d %0d, required 0 8 0 1", s1_a1, s1_a2, s1_b1, s1_b2);
    end
    checks++;
    if (s1_busy != 1 || s1_count != 0) begin
      errors++;
      $display("FAIL first_cycle_state: busy %0d count %0d, required 1 0", s1_busy, s1_count);
    end
    checks++;
    if (r_first_we != 10) begin
      errors++;
      $display("FAIL first_write_cycle: got %0d, required 10", r_first_we);
    end
    checks++;
    if (r_done_cyc != 209 || r_count != 208) begin
      errors++;
      $display("FAIL done_timing: done cycle %0d count %0d, required 209 208", r_done_cyc, r_count);
    end
    checks++;
    if (we_log.size() != 64) begin
      errors++;
      $display("FAIL write_count: got %0d, required 64", we_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (we_log[i] != first4[i] || we_log[60+i] != last4[i]) begin
          errors++;
          $display("FAIL c_addr_order: idx %0d got %0d/%0d, required %0d/%0d",
                   i, we_log[i], we_log[60+i], first4[i], last4[i]);
        end
      end
    end
    for (int a = 0; a < 64; a++) begin
      checks++;
      if (c_mem[a] != a - 32) begin
        errors++;
        $display("FAIL identity_c[%0d]: got %0d, required %0d", a, c_mem[a], a - 32);
      end
    end
  endtask

  task automatic test_sign_width();
    for (int i = 0; i < 64; i++) begin
      a_mem[i] = -128;
      b_mem[i] = -128;
    end
    clear_c();
    run_mult(0, 0);
    checks++;
    if (r_clr != 16 || r_mac != 128) begin
      errors++;
      $display("FAIL mac_counts: clear %0d mac_en %0d, required 16 128", r_clr, r_mac);
    end
    for (int a = 0; a < 64; a++) begin
      checks++;
      if (c_mem[a] != 131072) begin
        errors++;
        $display("FAIL neg_c[%0d]: got %0d, required 131072", a, c_mem[a]);
      end
    end
  endtask

  task automatic test_start_ignored();
    load_general();
    clear_c();
    run_mult(5, 100);
    checks++;
    if (r_count != 208 || r_we != 64 || r_done_cyc != 209) begin
      errors++;
      $display("FAIL start_ignored: count %0d writes %0d done cycle %0d, required 208 64 209",
               r_count, r_we, r_done_cyc);
    end
    for (int a = 0; a < 64; a++) begin
      checks++;
      if (c_mem[a] != exp_c(a)) begin
        errors++;
        $display("FAIL general_c[%0d]: got %0d, required %0d", a, c_mem[a], exp_c(a));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    load_general();
    clear_c();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (c_we !== 1'b1 || prod_sel !== 2'd1 || c_addr !== 6'd7) begin
      errors++;
      $display("FAIL tile3_write_s1: we %b sel %0d addr %0d, required 1 1 7", c_we, prod_sel, c_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({c_we, busy, done, mac_en, macc_clear, prod_sel, c_addr, addrA1, addrA2, addrB1, addrB2, clock_count} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: we %b busy %b done %b mac %b addrA1 %0d cnt %0d, required all 0",
               c_we, busy, done, mac_en, addrA1, clock_count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || c_mem[14] != SENT || c_mem[15] != SENT) begin
      errors++;
      $display("FAIL reset_mid_no_write: busy %b c14 %0d c15 %0d, required 0 %0d %0d",
               busy, c_mem[14], c_mem[15], SENT, SENT);
    end
    clear_c();
    run_mult(0, 0);
    checks++;
    if (r_count != 208) begin
      errors++;
      $display("FAIL reset_mid_rerun_count: got %0d, required 208", r_count);
    end
    for (int a = 0; a < 64; a++) begin
      checks++;
      if (c_mem[a] != exp_c(a)) begin
        errors++;
        $display("FAIL rerun_c[%0d]: got %0d, required %0d", a, c_mem[a], exp_c(a));
      end
    end
  endtask

  task automatic test_relaunch();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL relaunch_precond: done %b, required 1", done);
    end
    for (int a = 0; a < 64; a++) prev_c[a] = c_mem[a];
    clear_c();
    run_mult(0, 0);
    checks++;
    if (s1_done != 0 || s1_count != 0 || s1_busy != 1) begin
      errors++;
      $display("FAIL relaunch_first_cycle: done %0d count %0d busy %0d, required 0 0 1",
               s1_done, s1_count, s1_busy);
    end
    checks++;
    if (r_count != 208) begin
      errors++;
      $display("FAIL relaunch_count: got %0d, required 208", r_count);
    end
    for (int a = 0; a < 64; a++) begin
      checks++;
      if (c_mem[a] != prev_c[a]) begin
        errors++;
        $display("FAIL relaunch_c[%0d]: got %0d, required %0d", a, c_mem[a], prev_c[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_sign_width();
    test_start_ignored();
    test_reset_mid_run();
    test_relaunch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
